// File: rtl/dadda_ks_mac_pkg.sv
// rtl/dadda_ks_mac_pkg.sv - shared widths, types and Dadda stage heights for the 8x8 MAC
//
// Purpose: common definitions for dadda_mul8 and dadda_ks_mac8.
// Ports:   none (package).
package dadda_ks_mac_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [ACC_W-1:0] acc_t;

  // Maximum column height allowed after each reduction stage of an
  // 8-row Dadda tree (8 -> 6 -> 4 -> 3 -> 2).
  function automatic int dadda_height(input int stage);
    case (stage)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/dadda_mul8.sv
// rtl/dadda_mul8.sv - combinational 8x8 unsigned Dadda-tree multiplier
//
// Purpose: p = a * b (full 16-bit product, no truncation).
// Ports:
//   a  input  op_t   multiplicand
//   b  input  op_t   multiplier
//   p  output acc_t  product
module dadda_mul8
  import dadda_ks_mac_pkg::*;
(
  input  op_t  a,
  input  op_t  b,
  output acc_t p
);

  // Bit heap: cur[c] holds the bits of weight 2^c, packed from index 0,
  // hc[c] is how many of them are live. The loops below are fully
  // bounded, so the heap bookkeeping folds away and only the adder
  // network remains.
  logic [7:0] cur [16];
  logic [7:0] nxt [16];
  int         hc  [16];
  int         hn  [16];
  int         k;
  int         d;
  int         rem;
  logic       x;
  logic       y;
  logic       z;
  acc_t       row0;
  acc_t       row1;

  always_comb begin
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    k    = 0;
    d    = 0;
    rem  = 0;
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < 16; c++) begin
      cur[4'(c)] = '0;
      nxt[4'(c)] = '0;
      hc[4'(c)]  = 0;
      hn[4'(c)]  = 0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cur[4'(i+j)][3'(hc[4'(i+j)])] = b[3'(i)] & a[3'(j)];
        hc[4'(i+j)] += 1;
      end
    end

    for (int s = 0; s < 4; s++) begin
      d = dadda_height(s);
      for (int c = 0; c < 16; c++) begin
        nxt[4'(c)] = '0;
        hn[4'(c)]  = 0;
      end
      // Columns are walked LSB first so the carries landing in column c
      // during this stage are already counted before c is reduced.
      // Dadda rule: add only as many adders as needed to reach height d,
      // using a half adder when exactly one bit must go.
      for (int c = 0; c < 16; c++) begin
        k = 0;
        for (int r = 0; r < 4; r++) begin
          rem = hc[4'(c)] - k;
          if (rem + hn[4'(c)] > d) begin
            x = cur[4'(c)][3'(k)];
            y = cur[4'(c)][3'(k+1)];
            if (rem + hn[4'(c)] == d + 1) begin
              z = 1'b0;
              k += 2;
            end else begin
              z = cur[4'(c)][3'(k+2)];
              k += 3;
            end
            nxt[4'(c)][3'(hn[4'(c)])] = x ^ y ^ z;
            hn[4'(c)] += 1;
            if (c < 15) begin
              nxt[4'(c+1)][3'(hn[4'(c+1)])] = (x & y) | (x & z) | (y & z);
              hn[4'(c+1)] += 1;
            end
          end
        end
        for (int r = 0; r < 8; r++) begin
          if (r >= k && r < hc[4'(c)]) begin
            nxt[4'(c)][3'(hn[4'(c)])] = cur[4'(c)][3'(r)];
            hn[4'(c)] += 1;
          end
        end
      end
      cur = nxt;
      hc  = hn;
    end

    for (int c = 0; c < 16; c++) begin
      row0[4'(c)] = cur[4'(c)][0];
      row1[4'(c)] = cur[4'(c)][1];
    end
  end

  // Final carry-propagate add of the two remaining rows.
  assign p = row0 + row1;

endmodule

// File: rtl/dadda_ks_mac8.sv
// rtl/dadda_ks_mac8.sv - 8x8 unsigned multiply-accumulate, Dadda multiplier + Kogge-Stone adder
//
// Purpose: each rising edge {cout,out} <= out + a*b + cin; 1-cycle latency.
// Option:  MAC_SATURATE_EN defined -> on overflow out clamps to 16'hFFFF
//          (cout=1 that cycle); otherwise out wraps modulo 2^16.
// Ports:
//   clk   input        clock, rising edge
//   rst   input        synchronous active-low reset
//   a     input  [7:0] multiplicand
//   b     input  [7:0] multiplier
//   cin   input        carry into accumulation LSB
//   out   output [15:0] registered accumulator
//   cout  output       registered carry-out of the last accumulation
module dadda_ks_mac8
  import dadda_ks_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [15:0] out,
  output logic       cout
);

  acc_t prod;
  acc_t hp;
  acc_t g;
  acc_t pp;
  acc_t sum;
  logic ks_cout;

  dadda_mul8 u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  // Kogge-Stone prefix adder: out + prod + cin. cin is folded into the
  // bit-0 generate so every g[i] becomes the carry out of bit i.
  // Shifting zeros into the low propagate bits is harmless: those
  // positions already hold their final group generate.
  always_comb begin
    hp    = out ^ prod;
    g     = out & prod;
    pp    = hp;
    g[0]  = g[0] | (hp[0] & cin);
    for (int l = 0; l < 4; l++) begin
      g  = g | (pp & (g << (1 << l)));
      pp = pp & (pp << (1 << l));
    end
    sum     = hp ^ {g[14:0], cin};
    ks_cout = g[15];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out  <= '0;
      cout <= 1'b0;
    end else begin
`ifdef MAC_SATURATE_EN
      out  <= ks_cout ? 16'hFFFF : sum;
`else
      out  <= sum;
`endif
      cout <= ks_cout;
    end
  end

endmodule

// File: tb/tb_dadda_ks_mac8.sv
// tb/tb_dadda_ks_mac8.sv - scoreboard bench for dadda_ks_mac8
module tb_dadda_ks_mac8;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic [15:0] dut_out;
  logic        dut_cout;

  typedef struct {
    int          tag;
    logic [15:0] out;
    logic        cout;
  } exp_t;

  typedef struct {
    logic        r;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vc;
    logic [15:0] wout;
    logic        wc;
    logic [15:0] sout;
    logic        sc;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  dadda_ks_mac8 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .out  (dut_out),
    .cout (dut_cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add_vec(input logic r, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [15:0] wo, input logic wcc,
                         input logic [15:0] so, input logic scc);
    vec_t v;
    v.r = r; v.va = va; v.vb = vb; v.vc = vc;
    v.wout = wo; v.wc = wcc; v.sout = so; v.sc = scc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [15:0] eo, input logic ec, input int tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    cin = vc;
    e.tag = tag; e.out = eo; e.cout = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per rising edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_out !== e.out || dut_cout !== e.cout) begin
          failures++;
          $display("FAIL step%0d: out=%0d cout=%0b expected out=%0d cout=%0b",
                   e.tag, dut_out, dut_cout, e.out, e.cout);
        end
      end
    end
  end

  initial begin
    logic [15:0] macc;
    logic        mc;
    logic [16:0] sum17;
    logic        rr;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;

    rst = 1'b0;
    a   = '0;
    b   = '0;
    cin = 1'b0;

    //      rst  a    b    cin  wrap out  c     sat out   c
    add_vec(0,   0,   0,   0,   0,     0,    0,     0);
    add_vec(1,   3,   2,   0,   6,     0,    6,     0);
    add_vec(1,   5,   1,   0,   11,    0,    11,    0);
    add_vec(1,   2,   3,   0,   17,    0,    17,    0);
    add_vec(1,   3,   3,   0,   26,    0,    26,    0);
    add_vec(1,   255, 255, 0,   65051, 0,    65051, 0);
    add_vec(1,   22,  12,  0,   65315, 0,    65315, 0);
    add_vec(0,   7,   7,   0,   0,     0,    0,     0);
    add_vec(1,   255, 255, 0,   65025, 0,    65025, 0);
    add_vec(1,   1,   26,  0,   65051, 0,    65051, 0);
    add_vec(1,   255, 255, 0,   64540, 1,    65535, 1);
    add_vec(1,   0,   0,   0,   64540, 0,    65535, 0);
    add_vec(1,   1,   1,   0,   64541, 0,    65535, 1);
    add_vec(0,   0,   0,   0,   0,     0,    0,     0);
    add_vec(1,   0,   0,   1,   1,     0,    1,     0);
    add_vec(1,   1,   1,   1,   3,     0,    3,     0);
    add_vec(1,   4,   5,   1,   24,    0,    24,    0);
    add_vec(1,   1,   2,   0,   26,    0,    26,    0);
    add_vec(0,   7,   7,   1,   0,     0,    0,     0);
    add_vec(1,   1,   1,   0,   1,     0,    1,     0);
    add_vec(1,   255, 255, 1,   65027, 0,    65027, 0);

    foreach (vecs[i]) begin
`ifdef MAC_SATURATE_EN
      drive(vecs[i].r, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].sout, vecs[i].sc, i);
`else
      drive(vecs[i].r, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].wout, vecs[i].wc, i);
`endif
    end

    macc = 16'd65027;
    mc   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rr = ($urandom_range(0, 63) != 0);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      if (!rr) begin
        macc = '0;
        mc   = 1'b0;
      end else begin
        sum17 = 17'(macc) + 17'(ra) * 17'(rb) + 17'(rc);
`ifdef MAC_SATURATE_EN
        macc = sum17[16] ? 16'hFFFF : sum17[15:0];
`else
        macc = sum17[15:0];
`endif
        mc = sum17[16];
      end
      drive(rr, ra, rb, rc, macc, mc, 1000 + i);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
